atomic_read_arbiter: RTL

//  Shares the 64-bit event counter's 32-bit req/ack read port among NUM_REQ requesters.

---
 rtl/atomic_read_arbiter_if.sv | 25 ++
 rtl/atomic_read_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/atomic_read_arbiter_if.sv
// atomic_read_arbiter_if: requester-side and counter-side signals of the atomic read arbiter.
interface atomic_read_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] rd_req_i;
    logic [NUM_REQ-1:0] rd_ack_o;
    logic               rd_err_o;
    logic [63:0]        rd_data_o;
    logic               busy_o;
    logic               req_o;
    logic               atomic_o;
    logic               ack_i;
    logic [31:0]        count_i;
    logic               proto_err_o;

    modport master (
        input  rd_req_i, ack_i, count_i,
        output rd_ack_o, rd_err_o, rd_data_o, busy_o, req_o, atomic_o, proto_err_o
    );

    modport slave (
        output rd_req_i, ack_i, count_i,
        input  rd_ack_o, rd_err_o, rd_data_o, busy_o, req_o, atomic_o, proto_err_o
    );
endinterface

// File: rtl/atomic_read_arbiter.sv
// atomic_read_arbiter: round-robin sharing of the 32-bit counter port for atomic two-beat 64-bit reads.
module atomic_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input logic                   clk,
    input logic                   reset,
    atomic_read_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LO, LO_WAIT, HI, HI_WAIT, DONE} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] pending, cand, ack_vec;
    logic [IW-1:0]      gnt, rr_last, win;
    logic [TW-1:0]      timer;
    logic [63:0]        data;
    logic               err, err_n, found, waiting, timeout, arb;
    logic               req_q, atomic_q, proto_err;

    assign waiting = state == LO_WAIT || state == HI_WAIT;
    assign timeout = timer == TW'(ACK_TIMEOUT);
    assign arb     = state == IDLE || state == DONE;
    assign ack_vec = state == DONE ? NUM_REQ'(1) << gnt : '0;
    // A request arriving in its own ack cycle survives the clear and is arbitrated at once.
    assign cand    = (pending & ~ack_vec) | bus.rd_req_i;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && cand[(int'(rr_last) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr_last) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? LO : IDLE;
            LO:      state_n = LO_WAIT;
            LO_WAIT: state_n = bus.ack_i ? HI : timeout ? DONE : LO_WAIT;
            HI:      state_n = HI_WAIT;
            HI_WAIT: state_n = bus.ack_i || timeout ? DONE : HI_WAIT;
            DONE:    state_n = found ? LO : IDLE;
            default: state_n = IDLE;
        endcase
        err_n = arb ? 1'b0 : err | (waiting && !bus.ack_i && timeout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            rr_last   <= IW'(NUM_REQ - 1);
            gnt       <= '0;
            timer     <= '0;
            data      <= '0;
            err       <= 1'b0;
            req_q     <= 1'b0;
            atomic_q  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= cand;
            err       <= err_n;
            timer     <= waiting ? timer + 1'b1 : '0;
            req_q     <= state_n == LO || state_n == HI;
            atomic_q  <= state_n == LO;
            proto_err <= proto_err | (bus.ack_i && !waiting);
            if (arb && found) begin
                gnt     <= win;
                rr_last <= win;
            end
            if (state == LO_WAIT && bus.ack_i) data[31:0] <= bus.count_i;
            if (state == HI_WAIT && bus.ack_i) data[63:32] <= bus.count_i;
        end
    end

    assign bus.rd_ack_o    = ack_vec;
    assign bus.rd_err_o    = state == DONE && err;
    assign bus.rd_data_o   = state == DONE && !err ? data : '0;
    assign bus.busy_o      = state != IDLE;
    assign bus.req_o       = req_q;
    assign bus.atomic_o    = atomic_q;
    assign bus.proto_err_o = proto_err;
endmodule
